// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, fault cause codes and the text
// region defaults that the PC register also uses for its reset value.
package core_pkg;

  localparam logic [31:0] TEXT_BASE_DEF = 32'h0040_0000;
  localparam logic [31:0] TEXT_SIZE_DEF = 32'h0000_1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_RANGE    = 2'b11;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check of a fetch address: word alignment first,
// then membership in the text region [TEXT_BASE, TEXT_BASE+TEXT_SIZE).
module fetch_addr_check
  import core_pkg::*;
#(
  parameter int unsigned    N         = 32,
  parameter logic [N-1:0]   TEXT_BASE = N'(TEXT_BASE_DEF),
  parameter logic [N-1:0]   TEXT_SIZE = N'(TEXT_SIZE_DEF)
) (
  input  logic [N-1:0] i_addr,
  output logic         o_ok,
  output logic [1:0]   o_cause
);

  logic [N-1:0] w_offset;
  logic         w_in_range;

  // Offset form avoids overflow when the region ends at the top of memory.
  assign w_offset   = i_addr - TEXT_BASE;
  assign w_in_range = (i_addr >= TEXT_BASE) && (w_offset < TEXT_SIZE);

  always_comb begin
    o_ok    = 1'b1;
    o_cause = FAULT_NONE;
    if (i_addr[1:0] != 2'b00) begin
      o_ok    = 1'b0;
      o_cause = FAULT_MISALIGN;
    end else if (!w_in_range) begin
      o_ok    = 1'b0;
      o_cause = FAULT_RANGE;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: issues one memory request per PC, holds the
// PC register stalled until decode takes the instruction, flags sticky faults.
module imem_fetch_ctrl
  import core_pkg::*;
#(
  parameter int unsigned    N         = 32,
  parameter logic [N-1:0]   TEXT_BASE = N'(TEXT_BASE_DEF),
  parameter logic [N-1:0]   TEXT_SIZE = N'(TEXT_SIZE_DEF),
  parameter int unsigned    TIMEOUT   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_value,
  input  logic         redirect,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [N-1:0] mem_req_addr,
  input  logic         mem_rsp_valid,
  input  logic [N-1:0] mem_rsp_data,
  output logic [N-1:0] instr_out,
  output logic         instr_valid,
  input  logic         decode_ready,
  output logic         stall,
  output logic         fault,
  output logic [1:0]   fault_cause
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_drop, w_drop_nxt;
  logic [N-1:0]     r_instr, w_instr_nxt;
  logic             r_fault, w_fault_nxt;
  logic [1:0]       r_cause, w_cause_nxt;
  logic             w_addr_ok;
  logic [1:0]       w_addr_cause;

  fetch_addr_check #(
    .N         (N),
    .TEXT_BASE (TEXT_BASE),
    .TEXT_SIZE (TEXT_SIZE)
  ) u_addr_check (
    .i_addr  (pc_value),
    .o_ok    (w_addr_ok),
    .o_cause (w_addr_cause)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
      r_instr <= '0;
      r_fault <= 1'b0;
      r_cause <= FAULT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drop  <= w_drop_nxt;
      r_instr <= w_instr_nxt;
      r_fault <= w_fault_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_drop_nxt    = r_drop;
    w_instr_nxt   = r_instr;
    w_fault_nxt   = r_fault;
    w_cause_nxt   = r_cause;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    instr_valid   = 1'b0;
    stall         = 1'b1;

    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;

      // Address is checked before any request leaves; a bad PC never reaches memory.
      ST_REQ: begin
        mem_req_addr = pc_value;
        if (!w_addr_ok) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = 1'b1;
          w_cause_nxt = w_addr_cause;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
            w_drop_nxt  = 1'b0;
          end
        end
      end

      // A redirect marks the outstanding response stale; it is consumed and refetched.
      ST_WAIT: begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        if (mem_rsp_valid) begin
          if (r_drop || redirect) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end else begin
            w_instr_nxt = mem_rsp_data;
            w_state_nxt = ST_VALID;
          end
        end else begin
          if (redirect) w_drop_nxt = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_FAULT;
            w_fault_nxt = 1'b1;
            w_cause_nxt = FAULT_TIMEOUT;
          end
        end
      end

      ST_VALID: begin
        instr_valid = 1'b1;
        if (redirect) begin
          w_state_nxt = ST_REQ;
        end else if (decode_ready) begin
          stall       = 1'b0;
          w_state_nxt = ST_REQ;
        end
      end

      ST_FAULT: w_state_nxt = ST_FAULT;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign instr_out   = r_instr;
  assign fault       = r_fault;
  assign fault_cause = r_cause;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized run against
// a PC/memory reference that checks every request address and delivered word.
module tb_imem_fetch_ctrl;

  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] SIZE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_value;
  logic        redirect;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        decode_ready;
  logic        stall;
  logic        fault;
  logic [1:0]  fault_cause;

  imem_fetch_ctrl #(
    .N         (32),
    .TEXT_BASE (BASE),
    .TEXT_SIZE (SIZE),
    .TIMEOUT   (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_value      (pc_value),
    .redirect      (redirect),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .decode_ready  (decode_ready),
    .stall         (stall),
    .fault         (fault),
    .fault_cause   (fault_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int deliveries = 0;

  // Observations taken at the falling edge of the current cycle
  logic        o_req, o_acc, o_stall, o_iv, o_fault;
  logic [31:0] o_addr, o_instr;
  logic [1:0]  o_cause;

  // Memory model: at most one outstanding request, fixed or random latency
  logic        mem_busy = 1'b0;
  logic [31:0] mem_a;
  int          mem_cnt = 0;
  int          mem_delay = 0;
  logic        rand_delay = 1'b0;
  int          force_rsp = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == BASE) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: observe at negedge, then advance PC / memory after posedge.
  task automatic step();
    @(negedge clk);
    o_req   = mem_req_valid;
    o_acc   = mem_req_valid && mem_req_ready;
    o_addr  = mem_req_addr;
    o_stall = stall;
    o_iv    = instr_valid;
    o_instr = instr_out;
    o_fault = fault;
    o_cause = fault_cause;
    if (o_req) check_val("req_addr", o_addr, pc_value);
    if (!o_stall) begin
      check_val("deliver_valid", o_iv, 1);
      check_val("deliver_instr", o_instr, imem(pc_value));
      deliveries++;
    end
    if (o_acc) begin
      mem_busy = 1'b1;
      mem_a    = o_addr;
      mem_cnt  = rand_delay ? int'($urandom_range(0, 5)) : mem_delay;
    end
    @(posedge clk);
    #1;
    if (!o_stall) begin
      pc_value = pc_value + 32'd4;
      if (pc_value >= BASE + SIZE) pc_value = BASE;
    end
    if (force_rsp > 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      force_rsp--;
    end else if (mem_busy && mem_cnt == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = imem(mem_a);
      mem_busy      = 1'b0;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      if (mem_busy) mem_cnt--;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect = 1'b0; mem_req_ready = 1'b0; decode_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_busy = 1'b0; force_rsp = 0;
    #1;
    check_val("rst_req_valid", mem_req_valid, 0);
    check_val("rst_req_addr", mem_req_addr, 0);
    check_val("rst_instr_valid", instr_valid, 0);
    check_val("rst_instr_out", instr_out, 0);
    check_val("rst_stall", stall, 1);
    check_val("rst_fault", fault, 0);
    check_val("rst_cause", fault_cause, 0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_to_accept(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!o_acc && n < budget);
    if (!o_acc) check_val("accept_timeout", 0, 1);
  endtask

  task automatic fault_case(input logic [31:0] p, input logic [1:0] cause);
    pc_value = p;
    do_reset();
    mem_req_ready = 1'b1;
    step();
    step();
    check_val("badpc_no_req", o_req, 0);
    step();
    check_val("badpc_fault", o_fault, 1);
    check_val("badpc_cause", o_cause, cause);
    check_val("badpc_stall", o_stall, 1);
    check_val("badpc_no_req2", o_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pc_value = BASE;
    redirect = 1'b0;

    // Basic 0-wait fetch: REQ, WAIT, VALID with a one-cycle stall release
    mem_delay = 0;
    do_reset();
    mem_req_ready = 1'b1; decode_ready = 1'b1;
    step();
    check_val("idle_req", o_req, 0);
    check_val("idle_stall", o_stall, 1);
    step();
    check_val("t1_req", o_req, 1);
    check_val("t1_addr", o_addr, BASE);
    step();
    check_val("t1_wait_stall", o_stall, 1);
    check_val("t1_wait_iv", o_iv, 0);
    step();
    check_val("t1_iv", o_iv, 1);
    check_val("t1_instr", o_instr, 32'h0050_0093);
    check_val("t1_stall", o_stall, 0);
    step();
    check_val("t1_next_stall", o_stall, 1);
    check_val("t1_next_addr", o_req ? o_addr : 32'hFFFF_FFFF, BASE + 32'd4);

    // Response after 5 idle WAIT cycles: no fault
    pc_value = BASE + 32'h20; mem_delay = 5;
    do_reset();
    mem_req_ready = 1'b1; decode_ready = 1'b1;
    run_to_accept(4);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_val("t2_wait_stall", o_stall, 1);
      check_val("t2_wait_fault", o_fault, 0);
      check_val("t2_wait_iv", o_iv, 0);
    end
    step();
    check_val("t2_iv", o_iv, 1);
    check_val("t2_stall", o_stall, 0);

    // No response within TIMEOUT WAIT cycles: timeout fault, terminal
    pc_value = BASE + 32'h24; mem_delay = 17;
    do_reset();
    mem_req_ready = 1'b1; decode_ready = 1'b1;
    run_to_accept(4);
    for (int k = 1; k <= TMO; k++) begin
      step();
      check_val("t2_pre_fault", o_fault, 0);
    end
    step();
    check_val("t2_fault", o_fault, 1);
    check_val("t2_cause", o_cause, 2'b10);
    check_val("t2_fault_stall", o_stall, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("t2_fault_hold", {o_fault, o_cause, o_stall, o_iv, o_req}, {1'b1, 2'b10, 1'b1, 1'b0, 1'b0});
    end

    // Redirect while waiting: stale response dropped, refetch at new PC
    pc_value = BASE; mem_delay = 2;
    do_reset();
    mem_req_ready = 1'b1; decode_ready = 1'b1;
    run_to_accept(4);
    pc_value = BASE + 32'h10; redirect = 1'b1;
    step();
    redirect = 1'b0;
    mem_delay = 0;
    step();
    check_val("t3_iv_w2", o_iv, 0);
    step();
    check_val("t3_iv_w3", o_iv, 0);
    step();
    check_val("t3_refetch_acc", o_acc, 1);
    check_val("t3_refetch_addr", o_addr, BASE + 32'h10);
    step();
    check_val("t3_refetch_w", o_iv, 0);
    step();
    check_val("t3_deliver_iv", o_iv, 1);
    check_val("t3_deliver", o_instr, imem(BASE + 32'h10));
    // Redirect in the same cycle as the response
    run_to_accept(4);
    pc_value = BASE + 32'h40; redirect = 1'b1;
    step();
    redirect = 1'b0;
    step();
    check_val("t3_same_iv", o_iv, 0);
    check_val("t3_same_addr", o_req ? o_addr : 32'hFFFF_FFFF, BASE + 32'h40);

    // Decode back-pressure in VALID, then redirect in VALID
    pc_value = BASE + 32'h100; mem_delay = 1;
    do_reset();
    mem_req_ready = 1'b1; decode_ready = 1'b0;
    run_to_accept(4);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("t4_hold_iv", o_iv, 1);
      check_val("t4_hold_instr", o_instr, imem(BASE + 32'h100));
      check_val("t4_hold_stall", o_stall, 1);
      check_val("t4_hold_noreq", o_req, 0);
    end
    decode_ready = 1'b1;
    step();
    check_val("t4_release", o_stall, 0);
    decode_ready = 1'b0;
    step();
    check_val("t4_next_addr", o_req ? o_addr : 32'hFFFF_FFFF, BASE + 32'h104);
    step();
    step();
    step();
    check_val("t4_valid2", o_iv, 1);
    pc_value = BASE + 32'h200; redirect = 1'b1; decode_ready = 1'b1;
    step();
    check_val("t4_redir_stall", o_stall, 1);
    redirect = 1'b0;
    step();
    check_val("t4_redir_iv", o_iv, 0);
    check_val("t4_redir_addr", o_req ? o_addr : 32'hFFFF_FFFF, BASE + 32'h200);

    // Illegal PCs and region boundaries
    fault_case(BASE + 32'h2, 2'b01);
    fault_case(BASE - 32'h4, 2'b11);
    fault_case(BASE + SIZE, 2'b11);
    pc_value = BASE + SIZE - 32'h4;
    do_reset();
    mem_req_ready = 1'b1;
    step();
    step();
    check_val("last_word_req", o_req, 1);

    // Asynchronous reset mid-WAIT; late response after release is ignored
    pc_value = BASE + 32'h30; mem_delay = 0;
    do_reset();
    mem_req_ready = 1'b1; decode_ready = 1'b1;
    run_to_accept(4);
    step();
    step();
    check_val("t6_first", o_instr, imem(BASE + 32'h30));
    mem_delay = 10;
    run_to_accept(4);
    step();
    step();
    reset = 1'b0;
    #1;
    check_val("t6_rst_req", mem_req_valid, 0);
    check_val("t6_rst_addr", mem_req_addr, 0);
    check_val("t6_rst_instr", instr_out, 0);
    check_val("t6_rst_iv", instr_valid, 0);
    check_val("t6_rst_stall", stall, 1);
    mem_busy = 1'b0; mem_req_ready = 1'b0; mem_delay = 0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    pc_value = BASE + 32'h60;
    @(posedge clk);
    #1 reset = 1'b1;
    force_rsp = 2;
    step();
    check_val("t6_idle_iv", o_iv, 0);
    step();
    check_val("t6_req_iv", o_iv, 0);
    check_val("t6_req_addr", o_req ? o_addr : 32'hFFFF_FFFF, BASE + 32'h60);
    mem_req_ready = 1'b1;
    run_to_accept(4);
    step();
    step();
    check_val("t6_restart_iv", o_iv, 1);
    check_val("t6_restart_instr", o_instr, imem(BASE + 32'h60));

    // Randomized traffic: every request at the current PC, every delivery = mem[PC]
    pc_value = BASE; rand_delay = 1'b1;
    do_reset();
    deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect = ($urandom_range(0, 15) == 0);
      if (redirect) pc_value = BASE + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      mem_req_ready = ($urandom_range(0, 3) != 0);
      decode_ready  = ($urandom_range(0, 2) != 0);
      step();
    end
    redirect = 1'b0;
    check_val("rand_no_fault", o_fault, 0);
    check_val("rand_deliveries", deliveries > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
